// File: rtl/mmio_console.sv
// Memory-mapped console transmitter: stores to TXDATA are queued and sent as UART frames on txd.
// Define CONSOLE_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_console #(
  parameter logic [31:0] BASE_ADDR    = 32'hA000_0000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [2:0]  memOp,
  output logic        sel,
  output logic [31:0] dout,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CONSOLE_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } tx_state_t;

  tx_state_t     state;
  logic [PW-1:0] wp, rp;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    shift;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic          ovf;
  logic          full, empty, tx_active;
  logic          push, push_ok, pop, ovf_clr, bit_end;
  logic [31:0]   status;
  logic          unused_bits;
`ifdef CONSOLE_PARITY_EN
  logic          par;
`endif

  assign unused_bits = ^{memOp, din[31:8], addr[1:0]};

  assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
  assign empty     = (wp == rp);
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign tx_active = (state != S_IDLE);
  assign busy      = tx_active || !empty;
  assign bit_end   = (clk_cnt == CNT_LAST);
  assign status    = {28'd0, ovf, tx_active, empty, full};

  // Pop decision uses the pre-edge pointers, so a byte pushed this edge is never popped the same edge.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == S_IDLE)
        pop = 1'b1;
      else if (state == S_STOP && bit_end)
        pop = 1'b1;
    end
  end

  assign push    = we && sel && !addr[2];
  assign push_ok = push && (!full || pop);
  assign ovf_clr = we && sel && addr[2] && din[3];

  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wp[AW-1:0]] <= din[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp   <= '0;
      rp   <= '0;
      ovf  <= 1'b0;
      dout <= '0;
    end else begin
      if (push_ok)
        wp <= wp + PW'(1);
      if (pop)
        rp <= rp + PW'(1);
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
      if (sel && !we)
        dout <= addr[2] ? status : '0;
      else
        dout <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      shift   <= '0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      txd     <= 1'b1;
`ifdef CONSOLE_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      if (pop) begin
        shift <= mem[rp[AW-1:0]];
`ifdef CONSOLE_PARITY_EN
        par   <= ^mem[rp[AW-1:0]];
`endif
      end
      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            state   <= S_START;
            clk_cnt <= '0;
            bit_cnt <= '0;
            txd     <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= S_DATA;
            txd     <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef CONSOLE_PARITY_EN
              state <= S_PARITY;
              txd   <= par;
`else
              state <= S_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
`ifdef CONSOLE_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= S_STOP;
            txd     <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            // Next queued byte starts immediately, so frames abut with no idle bit.
            if (!empty) begin
              state <= S_START;
              txd   <= 1'b0;
            end else begin
              state <= S_IDLE;
              txd   <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Scoreboarded bench for mmio_console: stored bytes are queued and matched against decoded txd frames.
module tb_mmio_console;

  localparam logic [31:0] BASE = 32'hA000_0000;
  localparam int C = 4;
  localparam int D = 8;
`ifdef CONSOLE_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we;
  logic [2:0]  memOp;
  logic        sel;
  logic [31:0] dout;
  logic        txd;
  logic        busy;

  mmio_console #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (D),
    .CLKS_PER_BIT(C)
  ) dut (
    .clock(clock),
    .reset(reset),
    .addr (addr),
    .din  (din),
    .we   (we),
    .memOp(memOp),
    .sel  (sel),
    .dout (dout),
    .txd  (txd),
    .busy (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int pcyc = 0;
  int frames_done = 0;
  logic [7:0] sb[$];
  int start_cyc[$];

  initial forever begin
    @(posedge clock);
    pcyc++;
  end

  // Frame decoder: compares every txd sample of a frame against the byte at the head of the scoreboard.
  logic       mon_active = 1'b0;
  logic       mon_valid = 1'b0;
  logic [7:0] mon_exp = 8'h00;
  int         mon_cnt = 0;
  int         mon_bit = 0;
  logic       mon_e;
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        start_cyc.push_back(pcyc);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          mon_valid = 1'b0;
          $display("FAIL unexpected_frame: frame started at cycle %0d, required no frame (scoreboard empty)", pcyc);
        end else begin
          mon_exp = sb[0];
          mon_valid = 1'b1;
        end
      end
    end else begin
      mon_cnt++;
      if (mon_valid) begin
        mon_bit = mon_cnt / C;
        if (mon_bit == 0) mon_e = 1'b0;
        else if (mon_bit <= 8) mon_e = mon_exp[mon_bit-1];
`ifdef CONSOLE_PARITY_EN
        else if (mon_bit == 9) mon_e = ^mon_exp;
`endif
        else mon_e = 1'b1;
        n_checks++;
        if (txd !== mon_e) begin
          n_fail++;
          $display("FAIL txd_bit: byte %h bit slot %0d sample %0d got %b required %b", mon_exp, mon_bit, mon_cnt, txd, mon_e);
        end
      end
      if (mon_cnt == NB*C-1) begin
        mon_active = 1'b0;
        if (mon_valid) void'(sb.pop_front());
        frames_done++;
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit expect_tx);
    @(negedge clock);
    addr  = a;
    din   = d;
    we    = 1'b1;
    memOp = 3'($urandom_range(0, 7));
    if (expect_tx) sb.push_back(d[7:0]);
  endtask

  task automatic idle();
    @(negedge clock);
    we   = 1'b0;
    addr = 32'h0;
    din  = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clock);
    we   = 1'b0;
    addr = a;
    @(negedge clock);
    v    = dout;
    addr = 32'h0;
  endtask

  task automatic wait_idle(input int bound, output int took);
    took = 0;
    do begin
      @(negedge clock);
      took++;
    end while (busy && took < bound);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, took);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0; we = 1'b0; addr = 32'h0; din = 32'h0; memOp = 3'd0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || dout !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: txd=%b busy=%b dout=%h required 1 0 0", txd, busy, dout);
    end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: txd=%b busy=%b required 1 0", txd, busy);
    end
    rd(BASE + 32'd4, v);
    n_checks++;
    if (v !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL reset_status: got %h required 00000002", v);
    end
  endtask

  task automatic test_window();
    logic [31:0] v;
    @(negedge clock);
    addr = BASE + 32'd7;
    #1;
    n_checks++;
    if (sel !== 1'b1) begin
      n_fail++;
      $display("FAIL sel_top: sel=%b required 1", sel);
    end
    addr = BASE + 32'd8;
    #1;
    n_checks++;
    if (sel !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_outside: sel=%b required 0", sel);
    end
    wr(BASE + 32'd8, 32'h11, 1'b0);
    wr(BASE - 32'd4, 32'h22, 1'b0);
    idle();
    rd(BASE, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL txdata_read: got %h required 00000000", v);
    end
    rd(BASE + 32'd4, v);
    n_checks++;
    if (v !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL outside_write: status %h required 00000002", v);
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    int n0, took;
    n0 = frames_done;
    wr(BASE, {24'h0, b}, 1'b1);
    idle();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_push: busy=%b required 1", busy);
    end
    wait_idle(400, took);
    n_checks++;
    if (took !== NB*C + 1) begin
      n_fail++;
      $display("FAIL frame_length: busy fell after %0d cycles required %0d", took, NB*C + 1);
    end
    n_checks++;
    if (frames_done !== n0 + 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL single_frame: frames %0d pending %0d required %0d 0", frames_done - n0, sb.size(), 1);
    end
  endtask

  task automatic test_back_to_back();
    int n0, k, took, gap;
    n0 = frames_done;
    k = start_cyc.size();
    wr(BASE, 32'h41, 1'b1);
    wr(BASE, 32'h42, 1'b1);
    idle();
    wait_idle(400, took);
    n_checks++;
    if (start_cyc.size() != k + 2 || frames_done != n0 + 2) begin
      n_fail++;
      $display("FAIL b2b_count: starts %0d frames %0d required 2 2", start_cyc.size() - k, frames_done - n0);
    end else begin
      gap = start_cyc[k+1] - start_cyc[k];
      n_checks++;
      if (gap != NB*C) begin
        n_fail++;
        $display("FAIL b2b_spacing: start-to-start %0d required %0d", gap, NB*C);
      end
    end
  endtask

  task automatic test_overflow();
    int n0, w1, took;
    logic [31:0] v;
    n0 = frames_done;
    for (int i = 0; i < 10; i++) begin
      wr(BASE, 32'h30 + 32'(i), i < 9);
      if (i == 0) w1 = pcyc;
    end
    idle();
    rd(BASE + 32'd4, v);
    n_checks++;
    if (v !== 32'h0000_000D) begin
      n_fail++;
      $display("FAIL ovf_set: status %h required 0000000d", v);
    end
    rd(BASE + 32'd4, v);
    n_checks++;
    if (v !== 32'h0000_000D) begin
      n_fail++;
      $display("FAIL ovf_sticky: status %h required 0000000d", v);
    end
    wr(BASE + 32'd4, 32'h8, 1'b0);
    rd(BASE + 32'd4, v);
    n_checks++;
    if (v !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL ovf_clear: status %h required 00000005", v);
    end
    // The stop bit of the first frame ends (and pops) on the edge after this negedge; push into the full FIFO there.
    while (pcyc < w1 + 41) @(negedge clock);
    n_checks++;
    if (pcyc != w1 + 41) begin
      n_fail++;
      $display("FAIL pop_sync: cycle %0d required %0d", pcyc, w1 + 41);
    end
    addr = BASE; din = 32'h5A; we = 1'b1;
    sb.push_back(8'h5A);
    idle();
    rd(BASE + 32'd4, v);
    n_checks++;
    if (v !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL full_push_pop: status %h required 00000005", v);
    end
    wait_idle(1000, took);
    n_checks++;
    if (frames_done != n0 + 10 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_frames: frames %0d pending %0d required 10 0", frames_done - n0, sb.size());
    end
    rd(BASE + 32'd4, v);
    n_checks++;
    if (v !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL drained_status: status %h required 00000002", v);
    end
  endtask

  task automatic test_reset_mid();
    int n0, k;
    logic [31:0] v;
    n0 = frames_done;
    k = start_cyc.size();
    wr(BASE, 32'hFF, 1'b1);
    wr(BASE, 32'h00, 1'b1);
    idle();
    repeat (20) @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || dout !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: txd=%b busy=%b dout=%h required 1 0 0", txd, busy, dout);
    end
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    rd(BASE + 32'd4, v);
    n_checks++;
    if (v !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL post_reset_status: status %h required 00000002", v);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      n_checks++;
      if (txd !== 1'b1) begin
        n_fail++;
        $display("FAIL residual_txd: txd=%b at cycle %0d after release, required 1", txd, i);
      end
    end
    n_checks++;
    if (frames_done != n0 || start_cyc.size() != k + 1) begin
      n_fail++;
      $display("FAIL residual_frame: completed %0d starts %0d required 0 1", frames_done - n0, start_cyc.size() - k);
    end
  endtask

`ifdef CONSOLE_PARITY_EN
  task automatic test_parity();
    test_single(8'h07);
    test_single(8'h03);
  endtask
`endif

  initial begin
    test_reset();
    test_window();
    test_single(8'h55);
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef CONSOLE_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_console.md
Name: mmio_console

Overview:
- Memory-mapped console transmitter on the CPU data-memory port, in parallel with the data memory.
- Decodes stores to its address window and buffers the bytes in a small FIFO.
- Serialises the bytes as 8N1 UART frames on txd.
- Exposes a status register that software polls before halting, so test programs can print.

Parameters:
- BASE_ADDR, 32'hA000_0000, base of the 8-byte register window.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- CLKS_PER_BIT, 16, clock cycles per UART bit; at least 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- addr  input  32  data-memory address from the CPU.
- din  input  32  store data from the CPU; only din[7:0] is used.
- we  input  1  store strobe; sampled on the rising edge of clock.
- memOp  input  3  access width code; ignored, every store is treated as a byte store.
- sel  output  1  combinational; 1 when addr[31:3] == BASE_ADDR[31:3].
- dout  output  32  registered read data.
- txd  output  1  UART serial output; idles at 1.
- busy  output  1  1 while the FIFO is non-empty or a frame is in flight.

Behaviour:
- Register map, addr[2]:
  - 0 = TXDATA, write-only; reads return 0.
  - 1 = STATUS, read/write.
- STATUS bits:
  - bit0 full; bit1 empty; bit2 tx_active; bit3 overflow (sticky).
  - bits 31:4 read as 0.
- Writes:
  - A write takes effect on a rising edge with we=1, sel=1, addr[2]=0: din[7:0] is pushed to the FIFO.
  - If the FIFO is full, the byte is dropped and overflow is set to 1.
  - A write to STATUS with din[3]=1 clears overflow. If an overflowing push happens on the same edge, the set wins.
- Reads:
  - dout is updated every edge when sel=1 and we=0 with the selected register; otherwise dout is 0.
  - Read latency is 1 cycle.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than log2(FIFO_DEPTH).
  - full = the pointers differ only in the MSB; empty = the pointers are equal.
  - Pointers wrap naturally.
  - A push and a pop on the same edge while full: the pop frees the slot and the push is accepted, with no overflow.
  - A push on the same edge as a pop while empty is not popped that cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. When the FIFO is non-empty, pop into the shift register, go to START, and clear the bit counter.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: txd = shift[0], LSB first. Shift after every CLKS_PER_BIT cycles. After 8 bits, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then go to START directly if the FIFO is non-empty (back-to-back frames with no idle gap), else IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Flags:
  - tx_active = 1 whenever the state is not IDLE.
  - busy = tx_active or not empty.
- Reset (reset=0, asynchronous):
  - State returns to IDLE; pointers, overflow and dout go to 0; txd goes to 1.
  - A frame in progress is abandoned and txd returns high immediately.
  - FIFO contents are discarded.
- Accesses outside the window have no effect. sel lets the system mux choose dout over the data memory's read data.

Optional Feature:
- CONSOLE_PARITY_EN. When defined:
  - An even-parity bit state, PARITY, sits between DATA and STOP.
  - txd carries the XOR of the 8 data bits for CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT cycles.
- When undefined, the frame is 8N1 with no parity state or logic.

Test Plan:
- Reset, then release with CLKS_PER_BIT=4:
  - Required: txd=1, busy=0, and a STATUS read returns 32'h0000_0002 one cycle later.
- Store 32'h0000_0055 to BASE_ADDR:
  - Required: txd drives 0, then 1,0,1,0,1,0,1,0, then 1, each for 4 cycles (40 cycles total). busy returns to 0 afterwards.
- Stores of 8'h41 then 8'h42 on consecutive cycles:
  - Required: the two frames are back-to-back, the 8'h42 start bit begins exactly 40 cycles after the 8'h41 start bit, and there is no idle gap.
- 10 stores in 10 consecutive cycles with FIFO_DEPTH=8:
  - Required: overflow=1 is set.
  - STATUS bit3=1 reads back until a STATUS write of 32'h8 clears it.
  - Exactly 9 bytes are transmitted (one popped early plus eight buffered).
- reset pulled low mid-DATA of frame 8'hFF:
  - Required: txd=1 immediately, the FIFO is empty after release, and no residual frame is sent.
- With CONSOLE_PARITY_EN, store 8'h07:
  - Required: parity bit = 1, frame length 44 cycles.
